// File: rtl/if_fetch_buffer.sv
// Fetch buffer between the PC register and decode: tags imem reads with their PC, queues returns.
// Latency: PC presented in cycle N, data returns in N+1, VALID_D_o rises in N+2 (no bypass).
// Backpressure: PC_HOLD_H_o freezes the PC once queued plus in-flight entries would reach DEPTH.
module if_fetch_buffer #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] PC_i,
    output logic [31:0] IMEM_ADDR_o,
    output logic        IMEM_REQ_o,
    input  logic [31:0] IMEM_RDATA_i,
    output logic        PC_HOLD_H_o,
    input  logic        STALL_H_i,
    input  logic        FLUSH_H_i,
    output logic [31:0] INSTR_o,
    output logic [31:0] PC_D_o,
    output logic        VALID_D_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t          buf_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            inflight_q;
    logic [31:0]     inflight_pc_q;

    logic            pop;
    logic            push;
    logic [CW:0]     occupancy;
    entry_t          head;

    assign VALID_D_o   = (count_q != '0);
    assign pop         = VALID_D_o & ~STALL_H_i;
    assign push        = inflight_q;
    assign IMEM_ADDR_o = PC_i;

    // Occupancy seen by the next fetch: queued + in flight, minus the slot freed by a same-cycle pop.
    assign occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign PC_HOLD_H_o = rst_i & ~FLUSH_H_i & (occupancy >= DEPTH_C);
    assign IMEM_REQ_o  = rst_i & ~PC_HOLD_H_o;

    // Head entry of the queue, replaced by a NOP bubble whenever the queue is empty.
    always_comb begin
        head    = buf_q[rd_ptr_q];
        INSTR_o = NOP_INSTR;
        PC_D_o  = 32'h0;
        if (VALID_D_o) begin
            INSTR_o = head.instr;
            PC_D_o  = head.pc;
        end
    end

    // Queue storage: capture the returning instruction with its tag; wrong-path returns are dropped.
    always_ff @(posedge clk_i) begin
        if (push && !FLUSH_H_i) begin
            buf_q[wr_ptr_q] <= '{instr: IMEM_RDATA_i, pc: inflight_pc_q};
        end
    end

    // Pointer, count and in-flight tracking; flush empties everything and untags the current fetch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
        end else begin
            inflight_pc_q <= PC_i;
            if (FLUSH_H_i) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                inflight_q <= 1'b0;
            end else begin
                inflight_q <= IMEM_REQ_o;
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: models the upstream PC register and a 1-cycle instruction memory.
// Latency: expected entries are queued as the PC register loads each address, checked as decode consumes.
// Backpressure: the PC model obeys PC_HOLD_H_o; queued-plus-in-flight occupancy is checked against DEPTH.
module tb_if_fetch_buffer;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] pc_q;
    logic [31:0] IMEM_ADDR_o;
    logic        IMEM_REQ_o;
    logic [31:0] imem_rdata;
    logic        PC_HOLD_H_o;
    logic        STALL_H_i;
    logic        FLUSH_H_i;
    logic [31:0] INSTR_o;
    logic [31:0] PC_D_o;
    logic        VALID_D_o;
    logic [31:0] flush_tgt;

    exp_t        exp_q[$];
    exp_t        got;
    exp_t        want;
    int          occ;
    int          occ_nxt;
    int          n_cmp;
    int          n_err;

    if_fetch_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .PC_i         (pc_q),
        .IMEM_ADDR_o  (IMEM_ADDR_o),
        .IMEM_REQ_o   (IMEM_REQ_o),
        .IMEM_RDATA_i (imem_rdata),
        .PC_HOLD_H_o  (PC_HOLD_H_o),
        .STALL_H_i    (STALL_H_i),
        .FLUSH_H_i    (FLUSH_H_i),
        .INSTR_o      (INSTR_o),
        .PC_D_o       (PC_D_o),
        .VALID_D_o    (VALID_D_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of decode controls just after the edge, then wait for the sampling edge.
    task automatic cyc(input logic s, input logic f, input logic [31:0] t);
        @(posedge clk_i);
        #1;
        STALL_H_i = s;
        FLUSH_H_i = f;
        flush_tgt = t;
        @(negedge clk_i);
    endtask

    // Synchronous instruction memory with one cycle of read latency.
    always @(posedge clk_i) begin
        imem_rdata <= mem_f(IMEM_ADDR_o);
    end

    // Upstream PC register; every address it loads is the next instruction decode must see.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q <= 32'h0;
            occ  <= 0;
            exp_q.delete();
            exp_q.push_back('{pc: 32'h0, instr: mem_f(32'h0)});
        end else begin
            if (FLUSH_H_i) begin
                pc_q <= flush_tgt;
                exp_q.delete();
                exp_q.push_back('{pc: flush_tgt, instr: mem_f(flush_tgt)});
                occ_nxt = 0;
            end else begin
                if (!PC_HOLD_H_o) begin
                    pc_q <= pc_q + 32'd4;
                    exp_q.push_back('{pc: pc_q + 32'd4, instr: mem_f(pc_q + 32'd4)});
                end
                occ_nxt = occ + int'(IMEM_REQ_o) - int'(VALID_D_o && !STALL_H_i);
            end
            n_cmp++;
            if (occ_nxt > DEPTH) begin
                n_err++;
                $display("FAIL overflow: occupancy %0d, limit %0d (t=%0t)", occ_nxt, DEPTH, $time);
            end
            occ <= occ_nxt;
        end
    end

    // Scoreboard monitor: every instruction decode consumes must be the oldest expected one.
    always @(negedge clk_i) begin
        if (rst_i && VALID_D_o && !STALL_H_i) begin
            n_cmp++;
            got = '{pc: PC_D_o, instr: INSTR_o};
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard: got pc=%h instr=%h, expected nothing", got.pc, got.instr);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_err++;
                    $display("FAIL scoreboard: got pc=%h instr=%h, expected pc=%h instr=%h",
                             got.pc, got.instr, want.pc, want.instr);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_i     = 1'b0;
        STALL_H_i = 1'b0;
        FLUSH_H_i = 1'b0;
        flush_tgt = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        chk("rst_valid", 32'(VALID_D_o), 32'h0);
        chk("rst_instr", INSTR_o, NOP);
        chk("rst_pc_d", PC_D_o, 32'h0);
        chk("rst_req", 32'(IMEM_REQ_o), 32'h0);
        chk("rst_hold", 32'(PC_HOLD_H_o), 32'h0);

        // Reset release and first fetches: valid two cycles after the first request.
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("c0_req", 32'(IMEM_REQ_o), 32'h1);
        chk("c0_valid", 32'(VALID_D_o), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("c1_valid", 32'(VALID_D_o), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("c2_valid", 32'(VALID_D_o), 32'h1);
        chk("c2_pc_d", PC_D_o, 32'h0);
        chk("c2_instr", INSTR_o, mem_f(32'h0));
        cyc(1'b0, 1'b0, 32'h0);
        chk("c3_pc_d", PC_D_o, 32'h4);
        cyc(1'b0, 1'b0, 32'h0);
        chk("c4_pc_d", PC_D_o, 32'h8);
        chk("c4_hold", 32'(PC_HOLD_H_o), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);

        // Three-cycle decode stall with head at 0x10.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            chk("stall_pc_d", PC_D_o, 32'h10);
            chk("stall_hold", 32'(PC_HOLD_H_o), 32'h1);
            chk("stall_req", 32'(IMEM_REQ_o), 32'h0);
        end
        cyc(1'b0, 1'b0, 32'h0);
        chk("rel_pc_d0", PC_D_o, 32'h10);
        chk("rel_hold", 32'(PC_HOLD_H_o), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("rel_pc_d1", PC_D_o, 32'h14);
        cyc(1'b0, 1'b0, 32'h0);
        chk("rel_pc_d2", PC_D_o, 32'h18);

        // Flush with a fetch in flight, redirect to 0x100.
        cyc(1'b0, 1'b1, 32'h100);
        chk("flush_hold", 32'(PC_HOLD_H_o), 32'h0);
        chk("flush_pc_d", PC_D_o, 32'h1C);
        cyc(1'b0, 1'b0, 32'h0);
        chk("flush_valid1", 32'(VALID_D_o), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("flush_valid2", 32'(VALID_D_o), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("redir_valid", 32'(VALID_D_o), 32'h1);
        chk("redir_pc_d", PC_D_o, 32'h100);

        // Flush together with stall on a full queue: flush wins.
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h200);
        chk("fs_hold", 32'(PC_HOLD_H_o), 32'h0);
        chk("fs_req", 32'(IMEM_REQ_o), 32'h1);
        cyc(1'b0, 1'b0, 32'h0);
        chk("fs_valid1", 32'(VALID_D_o), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("fs_valid2", 32'(VALID_D_o), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("fs_pc_d", PC_D_o, 32'h200);

        // Asynchronous reset mid-stream with a full queue.
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("pre_rst_pc_d", PC_D_o, 32'h204);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_valid", 32'(VALID_D_o), 32'h0);
        chk("arst_instr", INSTR_o, NOP);
        chk("arst_pc_d", PC_D_o, 32'h0);
        chk("arst_req", 32'(IMEM_REQ_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_i     = 1'b1;
        STALL_H_i = 1'b0;
        @(negedge clk_i);
        chk("rs_req", 32'(IMEM_REQ_o), 32'h1);
        cyc(1'b0, 1'b0, 32'h0);
        chk("rs_valid", 32'(VALID_D_o), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("rs_pc_d", PC_D_o, 32'h0);
        chk("rs_instr", INSTR_o, mem_f(32'h0));

        // Random stall/flush traffic against the scoreboard.
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0),
                {18'h0, 12'($urandom_range(0, 4095)), 2'b00});
        end
        repeat (8) cyc(1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
